// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: zero-latency instruction fetch port plus a
// big-endian byte-stream loader that holds the CPU in reset until a program is loaded.
module instr_mem_responder #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       progcntr,
   input  logic              fetch,
   output logic [15:0]       inst,
   output logic              oob_err,
   input  logic              ld_start,
   input  logic [ADDR_W:0]   ld_len,
   input  logic [7:0]        ld_byte,
   input  logic              ld_byte_valid,
   output logic              ld_byte_ready,
   output logic              ld_done,
   output logic [15:0]       ld_checksum,
   output logic              cpu_hold
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

   typedef enum logic [2:0] {BOOT, IDLE, LOAD_HI, LOAD_LO, DONE} state_t;

   state_t state, state_next;

   logic [15:0]       mem [DEPTH];
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_inc;
   logic [ADDR_W:0]   start_len;
   logic [7:0]        hi_byte;
   logic [15:0]       word;
   logic              start_ok;
   logic              hi_en;
   logic              wr_en;
   logic              in_range;
   logic              loading;

   assign start_len = (ld_len > DEPTH_LEN) ? DEPTH_LEN : ld_len;
   assign count_inc = count + LEN_ONE;
   assign word      = {hi_byte, ld_byte};
   assign in_range  = (progcntr[15:ADDR_W] == '0);
   assign loading   = (state == LOAD_HI) || (state == LOAD_LO);
   assign inst      = (fetch && in_range && !loading) ? mem[progcntr[ADDR_W-1:0]] : 16'h0000;
   assign ld_done   = (state == DONE);
   assign cpu_hold  = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      ld_byte_ready = 1'b0;
      start_ok      = 1'b0;
      hi_en         = 1'b0;
      wr_en         = 1'b0;
      case (state)
         BOOT, IDLE: begin
            if (ld_start) begin
               start_ok   = 1'b1;
               state_next = (start_len == '0) ? DONE : LOAD_HI;
            end
         end
         LOAD_HI: begin
            ld_byte_ready = 1'b1;
            if (ld_byte_valid) begin
               hi_en      = 1'b1;
               state_next = LOAD_LO;
            end
         end
         LOAD_LO: begin
            ld_byte_ready = 1'b1;
            if (ld_byte_valid) begin
               wr_en      = 1'b1;
               state_next = (count_inc == len) ? DONE : LOAD_HI;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   // Loader bookkeeping; len is clamped to depth so waddr can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr       <= '0;
         count       <= '0;
         len         <= '0;
         hi_byte     <= '0;
         ld_checksum <= '0;
         oob_err     <= 1'b0;
      end else begin
         if (start_ok) begin
            len         <= start_len;
            waddr       <= '0;
            count       <= '0;
            ld_checksum <= '0;
         end
         if (hi_en) begin
            hi_byte <= ld_byte;
         end
         if (wr_en) begin
            waddr       <= waddr + 1'b1;
            count       <= count_inc;
            ld_checksum <= ld_checksum + word;
         end
         if (fetch && !in_range) begin
            oob_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr] <= word;
      end
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: load, fetch, handshake gaps,
// zero-length load, out-of-range fetch, reset mid-load and length clamping.
module tb_instr_mem_responder;

   logic        clk;
   logic        rst_n;
   logic [15:0] progcntr;
   logic        fetch;
   logic [15:0] inst;
   logic        oob_err;
   logic        ld_start;
   logic [8:0]  ld_len;
   logic [7:0]  ld_byte;
   logic        ld_byte_valid;
   logic        ld_byte_ready;
   logic        ld_done;
   logic [15:0] ld_checksum;
   logic        cpu_hold;

   int vectors;
   int miscompares;

   instr_mem_responder #(.ADDR_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .progcntr      (progcntr),
      .fetch         (fetch),
      .inst          (inst),
      .oob_err       (oob_err),
      .ld_start      (ld_start),
      .ld_len        (ld_len),
      .ld_byte       (ld_byte),
      .ld_byte_valid (ld_byte_valid),
      .ld_byte_ready (ld_byte_ready),
      .ld_done       (ld_done),
      .ld_checksum   (ld_checksum),
      .cpu_hold      (cpu_hold)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and hold it until the responder takes it.
   task automatic applyStimulus(input logic [7:0] b);
      int n;
      ld_byte       = b;
      ld_byte_valid = 1'b1;
      n             = 0;
      @(negedge clk);
      while (!ld_byte_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("byte_ready", 16'(ld_byte_ready), 16'h0001);
      @(posedge clk);
      #1;
      ld_byte_valid = 1'b0;
   endtask

   task automatic readWord(input string tag, input logic [15:0] addr, input logic [15:0] expected);
      @(negedge clk);
      fetch    = 1'b1;
      progcntr = addr;
      #1;
      checkOutput(tag, inst, expected);
      fetch = 1'b0;
   endtask

   initial begin
      logic [15:0] sum;
      logic [7:0]  ib;
      logic [15:0] w;

      vectors       = 0;
      miscompares   = 0;
      clk           = 1'b0;
      rst_n         = 1'b0;
      fetch         = 1'b0;
      progcntr      = 16'h0000;
      ld_start      = 1'b0;
      ld_len        = 9'd0;
      ld_byte       = 8'h00;
      ld_byte_valid = 1'b0;

      #12;
      checkOutput("rst_cpu_hold", 16'(cpu_hold), 16'h0001);
      checkOutput("rst_ready", 16'(ld_byte_ready), 16'h0000);
      checkOutput("rst_done", 16'(ld_done), 16'h0000);
      checkOutput("rst_checksum", ld_checksum, 16'h0000);
      checkOutput("rst_oob", 16'(oob_err), 16'h0000);
      checkOutput("rst_inst", inst, 16'h0000);

      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("boot_hold", 16'(cpu_hold), 16'h0001);
      checkOutput("boot_ready", 16'(ld_byte_ready), 16'h0000);

      $display("[TB] three-word load");
      tick();
      ld_start = 1'b1;
      ld_len   = 9'd3;
      tick();
      ld_start = 1'b0;
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      applyStimulus(8'hAB);
      applyStimulus(8'hCD);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      @(negedge clk);
      checkOutput("l3_done", 16'(ld_done), 16'h0001);
      checkOutput("l3_checksum", ld_checksum, 16'hBE02);
      checkOutput("l3_hold_in_done", 16'(cpu_hold), 16'h0001);
      checkOutput("l3_ready_in_done", 16'(ld_byte_ready), 16'h0000);
      tick();
      @(negedge clk);
      checkOutput("l3_done_clear", 16'(ld_done), 16'h0000);
      checkOutput("l3_hold_fall", 16'(cpu_hold), 16'h0000);
      readWord("l3_mem0", 16'h0000, 16'h1234);
      readWord("l3_mem1", 16'h0001, 16'hABCD);
      readWord("l3_mem2", 16'h0002, 16'h0001);
      #1;
      checkOutput("no_fetch_inst", inst, 16'h0000);

      $display("[TB] two-word load with valid gaps and ignored ld_start");
      tick();
      ld_start = 1'b1;
      ld_len   = 9'd2;
      tick();
      foreach (w[i]) begin end
      for (int k = 0; k < 4; k++) begin
         ld_start      = 1'b1;
         ld_len        = 9'd0;
         ld_byte       = 8'hFF;
         ld_byte_valid = 1'b0;
         tick();
         ld_start = 1'b0;
         case (k)
            0: applyStimulus(8'h5A);
            1: applyStimulus(8'hA5);
            2: applyStimulus(8'hC3);
            default: applyStimulus(8'h3C);
         endcase
      end
      @(negedge clk);
      checkOutput("l2_done", 16'(ld_done), 16'h0001);
      checkOutput("l2_checksum", ld_checksum, 16'h1DE1);
      tick();
      readWord("l2_mem0", 16'h0000, 16'h5AA5);
      readWord("l2_mem1", 16'h0001, 16'hC33C);
      readWord("l2_mem2_untouched", 16'h0002, 16'h0001);

      $display("[TB] zero-length load");
      tick();
      ld_start = 1'b1;
      ld_len   = 9'd0;
      tick();
      ld_start = 1'b0;
      @(negedge clk);
      checkOutput("l0_done", 16'(ld_done), 16'h0001);
      checkOutput("l0_checksum", ld_checksum, 16'h0000);
      checkOutput("l0_hold", 16'(cpu_hold), 16'h0001);
      tick();
      @(negedge clk);
      checkOutput("l0_done_clear", 16'(ld_done), 16'h0000);
      checkOutput("l0_hold_fall", 16'(cpu_hold), 16'h0000);
      readWord("l0_mem0", 16'h0000, 16'h5AA5);

      $display("[TB] out-of-range fetch");
      tick();
      fetch    = 1'b1;
      progcntr = 16'h0100;
      #1;
      checkOutput("oob_inst", inst, 16'h0000);
      checkOutput("oob_before_edge", 16'(oob_err), 16'h0000);
      tick();
      progcntr = 16'h0000;
      #1;
      checkOutput("oob_set", 16'(oob_err), 16'h0001);
      checkOutput("oob_valid_fetch", inst, 16'h5AA5);
      fetch = 1'b0;
      tick();
      checkOutput("oob_sticky", 16'(oob_err), 16'h0001);

      $display("[TB] reset in the middle of a load");
      ld_start = 1'b1;
      ld_len   = 9'd2;
      tick();
      ld_start = 1'b0;
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_hold", 16'(cpu_hold), 16'h0001);
      checkOutput("mid_rst_ready", 16'(ld_byte_ready), 16'h0000);
      checkOutput("mid_rst_done", 16'(ld_done), 16'h0000);
      checkOutput("mid_rst_checksum", ld_checksum, 16'h0000);
      checkOutput("mid_rst_oob", 16'(oob_err), 16'h0000);
      fetch    = 1'b1;
      progcntr = 16'h0000;
      #1;
      checkOutput("mid_rst_mem0", inst, 16'h1122);
      fetch = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      ld_start = 1'b1;
      ld_len   = 9'd1;
      tick();
      ld_start = 1'b0;
      applyStimulus(8'h77);
      applyStimulus(8'h88);
      @(negedge clk);
      checkOutput("reload_done", 16'(ld_done), 16'h0001);
      checkOutput("reload_checksum", ld_checksum, 16'h7788);
      tick();
      readWord("reload_mem0", 16'h0000, 16'h7788);
      readWord("reload_mem1", 16'h0001, 16'hC33C);

      $display("[TB] oversize length clamped to depth");
      tick();
      ld_start = 1'b1;
      ld_len   = 9'h1FF;
      tick();
      ld_start = 1'b0;
      sum      = 16'h0000;
      for (int i = 0; i < 256; i++) begin
         ib  = 8'(i);
         w   = {ib, ~ib};
         sum = sum + w;
         applyStimulus(w[15:8]);
         applyStimulus(w[7:0]);
      end
      @(negedge clk);
      checkOutput("clamp_done", 16'(ld_done), 16'h0001);
      checkOutput("clamp_checksum", ld_checksum, sum);
      tick();
      @(negedge clk);
      checkOutput("clamp_hold_fall", 16'(cpu_hold), 16'h0000);
      checkOutput("clamp_ready_idle", 16'(ld_byte_ready), 16'h0000);
      readWord("clamp_mem_last", 16'h00FF, 16'hFF00);
      readWord("clamp_mem_first", 16'h0000, 16'h00FF);
      readWord("clamp_mem_mid", 16'h0080, 16'h807F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Instruction-memory responder on the far side of the control unit's fetch interface: returns the 16-bit instruction at progcntr whenever fetch is high.
- Contains a byte-stream program loader FSM that fills the memory and holds the CPU in reset (cpu_hold) until a program has been loaded.
- Sits between the host/boot byte source and the simple CPU's instruction port.

Parameters:
ADDR_W, 8, word-address width; depth = 2**ADDR_W words of 16 bits.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
progcntr  in  16  fetch word address from control unit
fetch  in  1  instruction read request
inst  out  16  instruction word returned to control unit
oob_err  out  1  sticky: fetch with address beyond depth
ld_start  in  1  pulse: begin program load
ld_len  in  ADDR_W+1  number of 16-bit words to load; sampled on ld_start
ld_byte  in  8  load data byte
ld_byte_valid  in  1  load byte valid
ld_byte_ready  out  1  responder accepts byte
ld_done  out  1  one-cycle pulse at end of load
ld_checksum  out  16  mod-2^16 sum of all words of the last load
cpu_hold  out  1  reset/hold to CPU (drive into CPU rst)

Behaviour:
- Reset (rst_n low, async): state=BOOT, cpu_hold=1, ld_byte_ready=0, ld_done=0, ld_checksum=0, oob_err=0, write address=0, word count=0, hi-byte reg=0. Memory array is not reset.
- Read path (combinational, zero latency; the CPU latches inst in the same cycle it asserts fetch):
  - fetch=1, progcntr[15:ADDR_W]==0, state not LOAD_HI/LOAD_LO: inst = mem[progcntr[ADDR_W-1:0]].
  - fetch=1, progcntr out of range: inst = 16'h0000; oob_err set at next edge, sticky until reset.
  - fetch=0, or any load state: inst = 16'h0000.
- FSM states: BOOT, IDLE, LOAD_HI, LOAD_LO, DONE.
  - BOOT/IDLE, ld_start=1: capture len = min(ld_len, 2**ADDR_W); clear write address, count and checksum. Next state LOAD_HI, or DONE if len==0. cpu_hold=1 from the next edge.
  - BOOT with no ld_start: stay in BOOT, cpu_hold=1.
  - IDLE: cpu_hold=0.
  - LOAD_HI: ld_byte_ready=1. On valid&ready, hi-byte reg <= ld_byte; go to LOAD_LO.
  - LOAD_LO: ld_byte_ready=1. On valid&ready: mem[waddr] <= {hi, ld_byte}; waddr++; checksum += word; count++. If count+1==len go to DONE, else go to LOAD_HI.
  - DONE: ld_done=1 for exactly this cycle; go to IDLE. cpu_hold falls on entry to IDLE.
- Byte order: first byte of each word is bits 15:8 (big-endian).
- ld_start during LOAD_HI/LOAD_LO/DONE is ignored. There is no abort except rst_n.
- Write address is ADDR_W bits. Clamping len to depth guarantees no wrap.
- ld_byte_valid without ready is not consumed. The source holds the byte until ready.
- Reset mid-load: immediate return to BOOT. Partially written memory keeps its contents; cpu_hold=1.

Test Plan:
- Reset, then ld_start with ld_len=3 and bytes 12 34 AB CD 00 01 -> mem[0..2]=1234,ABCD,0001; ld_done pulses one cycle after the 6th handshake; ld_checksum=BE02; cpu_hold falls the cycle after ld_done.
- After load, fetch=1 with progcntr=0,1,2 -> inst=1234, ABCD, 0001 in the same cycle; fetch=0 -> inst=0000.
- ld_byte_valid toggled every other cycle during a 2-word load -> only valid&ready cycles consumed; contents match; no extra writes.
- ld_start with ld_len=0 -> ld_done the next cycle, checksum=0000, memory unchanged, cpu_hold=0 afterwards.
- fetch with progcntr=0x0100 (ADDR_W=8) -> inst=0000, oob_err=1 and stays 1 through later valid fetches until rst_n.
- rst_n asserted after the 3rd byte of a 2-word load -> all outputs at reset values immediately; mem[0] holds the first word; a new load overwrites it correctly.
